// File: rtl/playram_scanout.sv
// Raster scanout for the playram frame buffer: 2x2 pixel doubling, RGB332 to RGB888 expansion,
// and VGA-style sync/DE generation through a fixed two-stage pipeline.
module playram_scanout #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter int unsigned FB_W       = 320,
    parameter int unsigned FB_H       = 240,
    parameter int unsigned ADDR_WIDTH = 17,
    parameter bit          HS_POL     = 1'b0,
    parameter bit          VS_POL     = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [7:0]            rd_data,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  de,
    output logic [23:0]           rgb,
    output logic                  frame_start,
    output logic                  vblank
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_ONE  = HW'(1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_ONE  = VW'(1);

    localparam logic [ADDR_WIDTH-1:0] FB_W_C = ADDR_WIDTH'(FB_W);
    localparam logic [ADDR_WIDTH-1:0] A_ONE  = ADDR_WIDTH'(1);

    if (H_ACTIVE != 2 * FB_W || V_ACTIVE != 2 * FB_H) begin : g_geom_check
        $error("playram_scanout: active raster must be exactly twice the frame buffer");
    end

    // Stage 0: raster counters and incremental read address
    logic [HW-1:0]         h_cnt_q, h_cnt_d;
    logic [VW-1:0]         v_cnt_q, v_cnt_d;
    logic [ADDR_WIDTH-1:0] line_base_q, line_base_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  h_wrap;

    always_comb begin
        h_cnt_d     = h_cnt_q;
        v_cnt_d     = v_cnt_q;
        line_base_d = line_base_q;
        rd_addr_d   = rd_addr_q;
        h_wrap      = (h_cnt_q == H_LAST);
        if (!en) begin
            h_cnt_d     = '0;
            v_cnt_d     = '0;
            line_base_d = '0;
            rd_addr_d   = '0;
        end else begin
            h_cnt_d = h_wrap ? '0 : h_cnt_q + H_ONE;
            if (h_wrap) begin
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + V_ONE;
                if (v_cnt_d == '0) begin
                    line_base_d = '0;
                end else if (!v_cnt_d[0] && (v_cnt_d < V_ACT)) begin
                    line_base_d = line_base_q + FB_W_C;
                end
            end
            // Address tracks the position the counters will hold next cycle, so rd_addr_q
            // always matches h_cnt_q/v_cnt_q; each frame-buffer pixel is read twice.
            if (v_cnt_d < V_ACT) begin
                if (h_cnt_d == '0) begin
                    rd_addr_d = line_base_d;
                end else if ((h_cnt_d < H_ACT) && !h_cnt_d[0]) begin
                    rd_addr_d = rd_addr_q + A_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            line_base_q <= '0;
            rd_addr_q   <= '0;
        end else begin
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            line_base_q <= line_base_d;
            rd_addr_q   <= rd_addr_d;
        end
    end

    // Stage-0 flags are qualified by en so a parked raster emits nothing
    logic s0_de, s0_hs, s0_vs, s0_fs, s0_vb;

    always_comb begin
        s0_de = en && (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        s0_hs = en && (h_cnt_q >= H_SS) && (h_cnt_q < H_SE);
        s0_vs = en && (v_cnt_q >= V_SS) && (v_cnt_q < V_SE);
        s0_fs = en && (h_cnt_q == '0) && (v_cnt_q == '0);
        s0_vb = en && (v_cnt_q >= V_ACT);
    end

    // Stage 1: flags wait alongside the RAM read
    logic p1_de_q, p1_de_d;
    logic p1_hs_q, p1_hs_d;
    logic p1_vs_q, p1_vs_d;
    logic p1_fs_q, p1_fs_d;
    logic p1_vb_q, p1_vb_d;

    always_comb begin
        p1_de_d = s0_de;
        p1_hs_d = s0_hs;
        p1_vs_d = s0_vs;
        p1_fs_d = s0_fs;
        p1_vb_d = s0_vb;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_de_q <= 1'b0;
            p1_hs_q <= 1'b0;
            p1_vs_q <= 1'b0;
            p1_fs_q <= 1'b0;
            p1_vb_q <= 1'b0;
        end else begin
            p1_de_q <= p1_de_d;
            p1_hs_q <= p1_hs_d;
            p1_vs_q <= p1_vs_d;
            p1_fs_q <= p1_fs_d;
            p1_vb_q <= p1_vb_d;
        end
    end

    // Stage 2: registered outputs
    logic [23:0] rgb_q, rgb_d;
    logic        de_q, de_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        frame_start_q, frame_start_d;
    logic        vblank_q, vblank_d;
    logic [2:0]  px_r, px_g;
    logic [1:0]  px_b;

    always_comb begin
        px_r          = rd_data[7:5];
        px_g          = rd_data[4:2];
        px_b          = rd_data[1:0];
        // Bit replication maps full-scale RGB332 to full-scale 8-bit channels
        rgb_d         = p1_de_q ? {px_r, px_r, px_r[2:1], px_g, px_g, px_g[2:1],
                                   px_b, px_b, px_b, px_b} : 24'h0;
        de_d          = p1_de_q;
        hsync_d       = p1_hs_q ? HS_POL : ~HS_POL;
        vsync_d       = p1_vs_q ? VS_POL : ~VS_POL;
        frame_start_d = p1_fs_q;
        vblank_d      = p1_vb_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q         <= 24'h0;
            de_q          <= 1'b0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            frame_start_q <= 1'b0;
            vblank_q      <= 1'b0;
        end else begin
            rgb_q         <= rgb_d;
            de_q          <= de_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
            vblank_q      <= vblank_d;
        end
    end

    assign rd_addr     = rd_addr_q;
    assign rgb         = rgb_q;
    assign de          = de_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = frame_start_q;
    assign vblank      = vblank_q;

endmodule

// File: tb/tb_playram_scanout.sv
// Bench for playram_scanout on a shrunken raster: a per-cycle scoreboard built from raster
// positions, plus vector tables and directed sequences for enable, reset and timing corners.
module tb_playram_scanout;

    localparam int H_ACTIVE = 16, H_FP = 2, H_SYNC = 3, H_BP = 3;
    localparam int V_ACTIVE = 8, V_FP = 1, V_SYNC = 2, V_BP = 2;
    localparam int FB_W = 8, FB_H = 4, AW = 17;
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME = H_TOTAL * V_TOTAL;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data = 8'h0;
    logic          hsync, vsync, de, frame_start, vblank;
    logic [23:0]   rgb;

    always #5 clk = ~clk;

    playram_scanout #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .FB_W(FB_W), .FB_H(FB_H), .ADDR_WIDTH(AW), .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .rd_addr(rd_addr), .rd_data(rd_data),
        .hsync(hsync), .vsync(vsync), .de(de), .rgb(rgb),
        .frame_start(frame_start), .vblank(vblank)
    );

    // Synchronous RAM, one clock read latency
    logic [7:0] mem [0:255];
    always @(posedge clk) rd_data <= mem[rd_addr[7:0]];

    typedef struct packed {
        logic        de, hs, vs, fs, vb;
        logic [23:0] rgb;
    } out_t;

    typedef struct {
        logic [7:0]  pix;
        logic [23:0] rgb;
    } vec_t;

    int   checks = 0;
    int   failures = 0;
    int   mh = 0, mv = 0;
    out_t expq[$];
    out_t sb_e, sb_a, sb_f;
    out_t idle_rec = '{de: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0, vb: 1'b0, rgb: 24'h0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at t=%0t", name, act, req, $time);
        end
    endtask

    // Channel scaling by rounding arithmetic rather than bit replication
    function automatic logic [23:0] expand_ref(input logic [7:0] p);
        int r, g, b;
        r = int'(p[7:5]);
        g = int'(p[4:2]);
        b = int'(p[1:0]);
        return {8'((r * 255 + 3) / 7), 8'((g * 255 + 3) / 7), 8'(b * 85)};
    endfunction

    // Scoreboard: each cycle predicts the output record due two cycles later
    always @(negedge clk) begin
        sb_a = '{de: de, hs: hsync, vs: vsync, fs: frame_start, vb: vblank, rgb: rgb};
        if (!rst_n) begin
            mh = 0;
            mv = 0;
            expq.delete();
            expq.push_back(idle_rec);
            expq.push_back(idle_rec);
            check("reset_outputs", 32'(sb_a), 32'(idle_rec));
        end else begin
            sb_e = idle_rec;
            if (en) begin
                sb_e.de  = (mh < H_ACTIVE) && (mv < V_ACTIVE);
                sb_e.hs  = !((mh >= H_ACTIVE + H_FP) && (mh < H_ACTIVE + H_FP + H_SYNC));
                sb_e.vs  = !((mv >= V_ACTIVE + V_FP) && (mv < V_ACTIVE + V_FP + V_SYNC));
                sb_e.fs  = (mh == 0) && (mv == 0);
                sb_e.vb  = (mv >= V_ACTIVE);
                if (sb_e.de) begin
                    sb_e.rgb = expand_ref(mem[(mv / 2) * FB_W + mh / 2]);
                    check("rd_addr", 32'(rd_addr), 32'((mv / 2) * FB_W + mh / 2));
                end
                mh++;
                if (mh == H_TOTAL) begin
                    mh = 0;
                    mv = (mv == V_TOTAL - 1) ? 0 : mv + 1;
                end
            end else begin
                mh = 0;
                mv = 0;
            end
            expq.push_back(sb_e);
            sb_f = expq.pop_front();
            check("pixel", 32'(sb_a), 32'(sb_f));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pos(input int h, input int v, input string name);
        int n = 0;
        while (!(mh == h && mv == v) && n < 2 * FRAME) begin
            tick();
            n++;
        end
        check(name, 32'(mh == h && mv == v), 32'd1);
    endtask

    vec_t vecs[6];
    int   n_cyc, n_hs, n_vs, n_de;

    initial begin
        vecs[0] = '{pix: 8'hE0, rgb: 24'hFF0000};
        vecs[1] = '{pix: 8'h1C, rgb: 24'h00FF00};
        vecs[2] = '{pix: 8'h03, rgb: 24'h0000FF};
        vecs[3] = '{pix: 8'hFF, rgb: 24'hFFFFFF};
        vecs[4] = '{pix: 8'h92, rgb: 24'h9292AA};
        vecs[5] = '{pix: 8'h25, rgb: 24'h242455};
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);

        // Reset state
        repeat (3) tick();
        check("reset_rd_addr", 32'(rd_addr), 32'd0);
        check("reset_hsync", 32'(hsync), 32'd1);
        check("reset_vsync", 32'(vsync), 32'd1);
        tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // First enable: frame_start/de exactly two clocks later, line 0 address sequence
        en = 1'b1;
        check("en_first_addr", 32'(rd_addr), 32'd0);
        tick();
        check("de_not_early", 32'(de), 32'd0);
        tick();
        check("first_de", 32'(de), 32'd1);
        check("first_frame_start", 32'(frame_start), 32'd1);
        for (int h = 2; h < H_ACTIVE; h++) begin
            check("line0_addr", 32'(rd_addr), 32'(h / 2));
            tick();
        end

        // Frame timing: period and sync/DE occupancy between frame_start pulses
        n_cyc = 0;
        while (!frame_start && n_cyc < 2 * FRAME) begin
            tick();
            n_cyc++;
        end
        check("fs_found", 32'(frame_start), 32'd1);
        n_cyc = 0; n_hs = 0; n_vs = 0; n_de = 0;
        do begin
            n_cyc++;
            n_hs += int'(!hsync);
            n_vs += int'(!vsync);
            n_de += int'(de);
            tick();
        end while (!frame_start && n_cyc < 2 * FRAME);
        check("frame_period", 32'(n_cyc), 32'(FRAME));
        check("hsync_count", 32'(n_hs), 32'(H_SYNC * V_TOTAL));
        check("vsync_count", 32'(n_vs), 32'(V_SYNC * H_TOTAL));
        check("de_count", 32'(n_de), 32'(H_ACTIVE * V_ACTIVE));

        // Last visible pixel and frame wrap
        wait_pos(H_ACTIVE - 1, V_ACTIVE - 1, "reach_last_pixel");
        check("last_addr", 32'(rd_addr), 32'(FB_W * FB_H - 1));
        wait_pos(0, 2, "reach_line2");
        check("line2_addr", 32'(rd_addr), 32'(FB_W));

        // Colour expansion table
        for (int i = 0; i < 6; i++) begin
            en = 1'b0;
            repeat (3) tick();
            for (int a = 0; a < 256; a++) mem[a] = vecs[i].pix;
            tick();
            en = 1'b1;
            tick();
            tick();
            check("vec_rgb", 32'(rgb), 32'(vecs[i].rgb));
            check("vec_fs", 32'(frame_start), 32'd1);
        end

        // Mid-frame enable drop, drain, and restart
        en = 1'b0;
        repeat (3) tick();
        for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
        en = 1'b1;
        wait_pos(5, 3, "reach_drop_point");
        en = 1'b0;
        tick();
        check("park_addr", 32'(rd_addr), 32'd0);
        tick();
        check("drain_idle", 32'({de, hsync, vsync, frame_start, vblank, rgb}),
              32'({1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0}));
        repeat (3) tick();
        en = 1'b1;
        check("restart_addr", 32'(rd_addr), 32'd0);
        tick();
        tick();
        check("restart_fs", 32'(frame_start), 32'd1);

        // Randomised enable with random frame-buffer contents
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 99) < 3) en = ~en;
            tick();
        end

        // Asynchronous reset mid-line
        en = 1'b1;
        wait_pos(7, 1, "reach_reset_point");
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_addr", 32'(rd_addr), 32'd0);
        check("async_rst_out", 32'({de, hsync, vsync, frame_start, vblank, rgb}),
              32'({1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0}));
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        repeat (700) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
